load_responder: RTL and testbench

Buffer-side responder for the Control_unit load phase. It accepts per-cycle IFM and weight write requests (req + word address) and coalesces the repeated addresses produced by the byte-counter-shifted addressing. It pairs each surviving request with one 32-bit word from an input data stream, writes the word into the IFM or weight BRAM port, and returns a one-cycle `addr_valid` acknowledge per completed word. It sits between the external load stream and the IFM/weight buffers.

---
 rtl/load_pkg.sv | 18 +
 rtl/req_fifo.sv | 54 +++++
 rtl/load_responder.sv | 209 ++++++++++++++++++++
 tb/tb_load_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load-phase responder: channel encoding,
// default data-path widths and a saturating counter helper.
package load_pkg;

    localparam int LOAD_ADDR_W = 32;
    localparam int LOAD_DATA_W = 32;

    typedef enum logic {
        CH_IFM = 1'b0,
        CH_WGT = 1'b1
    } channel_t;

    // Word counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Small synchronous request queue. Push and pop may happen in the same
// cycle, including when full, because the head is read combinationally
// before the edge that overwrites its slot.
module req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage array carries no reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/load_responder.sv
// Buffer-side responder for the load phase. Coalesces repeated word
// addresses per channel, queues the survivors, pairs each with one stream
// word under round-robin arbitration and writes it into the IFM or weight
// BRAM port one cycle after the stream handshake.
module load_responder
    import load_pkg::*;
#(
    parameter int ADDR_W     = LOAD_ADDR_W,
    parameter int DATA_W     = LOAD_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_ifm,
    input  logic [ADDR_W-1:0] addr_ifm,
    input  logic              req_wgt,
    input  logic [ADDR_W-1:0] addr_wgt,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ifm_we,
    output logic [ADDR_W-1:0] ifm_waddr,
    output logic [DATA_W-1:0] ifm_wdata,
    output logic              wgt_we,
    output logic [ADDR_W-1:0] wgt_waddr,
    output logic [DATA_W-1:0] wgt_wdata,
    output logic              addr_valid,
    output logic              busy,
    output logic [15:0]       ifm_count,
    output logic [15:0]       wgt_count,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] last_addr_ifm;
    logic [ADDR_W-1:0] last_addr_wgt;
    logic              last_vld_ifm;
    logic              last_vld_wgt;

    logic [ADDR_W-1:0] ifm_head;
    logic [ADDR_W-1:0] wgt_head;
    logic [CNT_W-1:0]  ifm_occ;
    logic [CNT_W-1:0]  wgt_occ;
    logic              ifm_empty;
    logic              wgt_empty;
    logic              ifm_full;
    logic              wgt_full;

    channel_t          rr;
    channel_t          grant;
    logic              handshake;
    logic              pop_ifm;
    logic              pop_wgt;

    logic              ifm_dup;
    logic              wgt_dup;
    logic              ifm_fresh;
    logic              wgt_fresh;
    logic              ifm_push;
    logic              wgt_push;
    logic              ifm_drop;
    logic              wgt_drop;

    assign ifm_empty = (ifm_occ == '0);
    assign wgt_empty = (wgt_occ == '0);
    assign ifm_full  = (ifm_occ == CNT_W'(FIFO_DEPTH));
    assign wgt_full  = (wgt_occ == CNT_W'(FIFO_DEPTH));

    assign busy      = ~ifm_empty | ~wgt_empty;
    assign s_ready   = busy & ~clear;
    assign handshake = s_valid & s_ready;

    // Round-robin pointer decides only when both heads compete.
    always_comb begin
        grant = rr;
        if (ifm_empty) begin
            grant = CH_WGT;
        end else if (wgt_empty) begin
            grant = CH_IFM;
        end
    end

    assign pop_ifm = handshake & (grant == CH_IFM);
    assign pop_wgt = handshake & (grant == CH_WGT);

    // A full queue still accepts when its own head leaves in the same cycle.
    assign ifm_dup   = last_vld_ifm & (addr_ifm == last_addr_ifm);
    assign wgt_dup   = last_vld_wgt & (addr_wgt == last_addr_wgt);
    assign ifm_fresh = req_ifm & ~ifm_dup & ~clear;
    assign wgt_fresh = req_wgt & ~wgt_dup & ~clear;
    assign ifm_push  = ifm_fresh & (~ifm_full | pop_ifm);
    assign wgt_push  = wgt_fresh & (~wgt_full | pop_wgt);
    assign ifm_drop  = ifm_fresh & ifm_full & ~pop_ifm;
    assign wgt_drop  = wgt_fresh & wgt_full & ~pop_wgt;

    req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ifm_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (ifm_push),
        .push_data (addr_ifm),
        .pop       (pop_ifm),
        .head      (ifm_head),
        .count     (ifm_occ)
    );

    req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wgt_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (wgt_push),
        .push_data (addr_wgt),
        .pop       (pop_wgt),
        .head      (wgt_head),
        .count     (wgt_occ)
    );

    // Remember the last accepted address per channel; dropped requests leave it alone so retries are re-evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr_ifm <= '0;
            last_addr_wgt <= '0;
            last_vld_ifm  <= 1'b0;
            last_vld_wgt  <= 1'b0;
        end else if (clear) begin
            last_vld_ifm  <= 1'b0;
            last_vld_wgt  <= 1'b0;
        end else begin
            if (ifm_push) begin
                last_addr_ifm <= addr_ifm;
                last_vld_ifm  <= 1'b1;
            end
            if (wgt_push) begin
                last_addr_wgt <= addr_wgt;
                last_vld_wgt  <= 1'b1;
            end
        end
    end

    // Arbiter pointer alternates after every grant; overflow is sticky until clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= CH_IFM;
            overflow <= 1'b0;
        end else if (clear) begin
            rr       <= CH_IFM;
            overflow <= 1'b0;
        end else begin
            if (handshake) begin
                rr <= channel_t'(~grant);
            end
            if (ifm_drop || wgt_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Write stage: one registered BRAM write per handshake; a write already here is not cancelled by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_we     <= 1'b0;
            wgt_we     <= 1'b0;
            addr_valid <= 1'b0;
            ifm_waddr  <= '0;
            ifm_wdata  <= '0;
            wgt_waddr  <= '0;
            wgt_wdata  <= '0;
        end else begin
            ifm_we     <= pop_ifm;
            wgt_we     <= pop_wgt;
            addr_valid <= handshake;
            if (pop_ifm) begin
                ifm_waddr <= ifm_head;
                ifm_wdata <= s_data;
            end
            if (pop_wgt) begin
                wgt_waddr <= wgt_head;
                wgt_wdata <= s_data;
            end
        end
    end

    // Word counters advance together with the write they account for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_count <= '0;
            wgt_count <= '0;
        end else if (clear) begin
            ifm_count <= '0;
            wgt_count <= '0;
        end else begin
            if (pop_ifm) begin
                ifm_count <= sat_inc(ifm_count);
            end
            if (pop_wgt) begin
                wgt_count <= sat_inc(wgt_count);
            end
        end
    end

endmodule

// File: tb/tb_load_responder.sv
// Self-checking bench for load_responder: directed scenarios plus a
// randomized run, all compared cycle by cycle against a queue-based model.
module tb_load_responder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        req_ifm;
    logic [31:0] addr_ifm;
    logic        req_wgt;
    logic [31:0] addr_wgt;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ifm_we;
    logic [31:0] ifm_waddr;
    logic [31:0] ifm_wdata;
    logic        wgt_we;
    logic [31:0] wgt_waddr;
    logic [31:0] wgt_wdata;
    logic        addr_valid;
    logic        busy;
    logic [15:0] ifm_count;
    logic [15:0] wgt_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state: per-channel address queues and bookkeeping.
    logic [31:0] mq_ifm[$];
    logic [31:0] mq_wgt[$];
    logic [31:0] m_last[2];
    bit          m_lv[2];
    bit          m_rr;
    bit          m_ovf;
    int          m_cnt[2];
    bit          m_we[2];
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    bit          m_av;

    load_responder #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_ifm    (req_ifm),
        .addr_ifm   (addr_ifm),
        .req_wgt    (req_wgt),
        .addr_wgt   (addr_wgt),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ifm_we     (ifm_we),
        .ifm_waddr  (ifm_waddr),
        .ifm_wdata  (ifm_wdata),
        .wgt_we     (wgt_we),
        .wgt_waddr  (wgt_waddr),
        .wgt_wdata  (wgt_wdata),
        .addr_valid (addr_valid),
        .busy       (busy),
        .ifm_count  (ifm_count),
        .wgt_count  (wgt_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq_ifm.delete();
        mq_wgt.delete();
        m_lv   = '{0, 0};
        m_last = '{32'd0, 32'd0};
        m_rr   = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = '{0, 0};
        m_we   = '{0, 0};
        m_av   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Offer one request to a channel after that channel's pop has been taken.
    task automatic modelOffer(input int ch, input logic req, input logic [31:0] a);
        int sz;
        if (!req) return;
        if (m_lv[ch] && m_last[ch] == a) return;
        sz = (ch == 0) ? mq_ifm.size() : mq_wgt.size();
        if (sz < DEPTH) begin
            if (ch == 0) mq_ifm.push_back(a);
            else         mq_wgt.push_back(a);
            m_last[ch] = a;
            m_lv[ch]   = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic modelStep(input logic ri, input logic [31:0] ai, input logic rw,
                             input logic [31:0] aw, input logic [31:0] d,
                             input logic v, input logic clr);
        bit          hs;
        int          g;
        logic [31:0] a;
        hs   = v && (mq_ifm.size() + mq_wgt.size() > 0) && !clr;
        m_we = '{0, 0};
        m_av = hs;
        if (hs) begin
            if (mq_ifm.size() > 0 && mq_wgt.size() > 0) g = int'(m_rr);
            else g = (mq_ifm.size() == 0) ? 1 : 0;
            if (g == 0) a = mq_ifm.pop_front();
            else        a = mq_wgt.pop_front();
            m_we[g] = 1'b1;
            m_waddr = a;
            m_wdata = d;
            if (m_cnt[g] < 65535) m_cnt[g]++;
            m_rr = (g == 0);
        end
        if (clr) begin
            mq_ifm.delete();
            mq_wgt.delete();
            m_lv  = '{0, 0};
            m_cnt = '{0, 0};
            m_ovf = 1'b0;
            m_rr  = 1'b0;
        end else begin
            modelOffer(0, ri, ai);
            modelOffer(1, rw, aw);
        end
    endtask

    task automatic checkAll();
        bit mbusy;
        mbusy = (mq_ifm.size() + mq_wgt.size()) > 0;
        checkOutput("ifm_we", {31'd0, ifm_we}, {31'd0, m_we[0]});
        checkOutput("wgt_we", {31'd0, wgt_we}, {31'd0, m_we[1]});
        checkOutput("addr_valid", {31'd0, addr_valid}, {31'd0, m_av});
        checkOutput("busy", {31'd0, busy}, {31'd0, mbusy});
        checkOutput("s_ready", {31'd0, s_ready}, {31'd0, mbusy && !clear});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        checkOutput("ifm_count", {16'd0, ifm_count}, m_cnt[0]);
        checkOutput("wgt_count", {16'd0, wgt_count}, m_cnt[1]);
        if (m_we[0]) begin
            checkOutput("ifm_waddr", ifm_waddr, m_waddr);
            checkOutput("ifm_wdata", ifm_wdata, m_wdata);
        end
        if (m_we[1]) begin
            checkOutput("wgt_waddr", wgt_waddr, m_waddr);
            checkOutput("wgt_wdata", wgt_wdata, m_wdata);
        end
    endtask

    // Called at a falling edge: drive inputs, check, step the model, move to the next falling edge.
    task automatic applyStimulus(input logic ri, input logic [31:0] ai, input logic rw,
                                 input logic [31:0] aw, input logic [31:0] d,
                                 input logic v, input logic clr);
        req_ifm  = ri;
        addr_ifm = ai;
        req_wgt  = rw;
        addr_wgt = aw;
        s_data   = d;
        s_valid  = v;
        clear    = clr;
        #1;
        checkAll();
        modelStep(ri, ai, rw, aw, d, v, clr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req_ifm = 0; addr_ifm = 0; req_wgt = 0; addr_wgt = 0;
        s_data = 0; s_valid = 0; clear = 0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_ifm_waddr", ifm_waddr, 32'd0);
        checkOutput("rst_ifm_wdata", ifm_wdata, 32'd0);
        checkOutput("rst_wgt_waddr", wgt_waddr, 32'd0);
        checkOutput("rst_wgt_wdata", wgt_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_ifm = 0; addr_ifm = 0; req_wgt = 0; addr_wgt = 0;
        s_data = 0; s_valid = 0; clear = 0;
        modelReset();
        @(negedge clk);
        doReset();

        $display("[TB] coalescing");
        for (int i = 0; i < 8; i++) applyStimulus(1, (i < 4) ? 32'd0 : 32'd1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'hA0, 1, 0);
        applyStimulus(0, 0, 0, 0, 32'hA1, 1, 0);
        checkOutput("coal_ifm_count", {16'd0, ifm_count}, 32'd2);
        checkOutput("coal_wgt_count", {16'd0, wgt_count}, 32'd0);
        idle(2);

        $display("[TB] arbitration");
        doReset();
        applyStimulus(1, 5, 1, 9, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'hD0, 1, 0);
        applyStimulus(0, 0, 0, 0, 32'hD1, 1, 0);
        checkOutput("arb_busy_low", {31'd0, busy}, 32'd0);
        idle(2);

        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, i, 0, 0, 0, 0, 0);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 32'hB0 + i, 1, 0);
        checkOutput("ovf_ifm_count", {16'd0, ifm_count}, 32'd4);
        idle(2);

        $display("[TB] backpressure");
        doReset();
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        idle(10);
        applyStimulus(0, 0, 0, 0, 32'hC0, 1, 0);
        applyStimulus(0, 0, 0, 0, 32'hC1, 1, 0);
        idle(2);

        $display("[TB] full queue with pop");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, i, 0, 0, 0, 0, 0);
        applyStimulus(1, 7, 0, 0, 32'hE0, 1, 0);
        checkOutput("fullpop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 32'hE1 + i, 1, 0);
        checkOutput("fullpop_count", {16'd0, ifm_count}, 32'd5);
        idle(2);

        $display("[TB] reset and clear mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1, i, 0, 0, 0, 0, 0);
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_requeue", {31'd0, busy}, 32'd1);
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, i, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'hF0, 1, 0);
        applyStimulus(1, 5, 0, 0, 32'hF1, 1, 1);
        checkOutput("clr_busy", {31'd0, busy}, 32'd0);
        checkOutput("clr_count", {16'd0, ifm_count}, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("clr_requeue", {31'd0, busy}, 32'd1);
        idle(2);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic ri, rw, v, clr;
            logic [31:0] ai, aw, d;
            if (c == 200) doReset();
            ri  = ($urandom_range(0, 99) < 45);
            rw  = ($urandom_range(0, 99) < 45);
            ai  = $urandom_range(0, 5);
            aw  = $urandom_range(0, 5);
            d   = $urandom;
            v   = (((c / 50) % 2) == 1) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 30);
            clr = ($urandom_range(0, 49) == 0);
            applyStimulus(ri, ai, rw, aw, d, v, clr);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
